bht_update_queue: RTL and testbench

- Downstream companion of the 1024-entry, 2-bit branch history table.
- Holds in-flight predictions in order: 10-bit index plus the counter state read at predict time.
- On in-order branch resolution, computes the next 2-bit hysteresis state and drives the BHT write port (wr/addr/in).
- Flags mispredicts to the fetch stage.

---
 rtl/bht_update_queue.sv | 168 ++++++++++++++++
 tb/tb_bht_update_queue.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bht_update_queue.sv
// bht_update_queue
// In-order queue of in-flight branch predictions sitting beside a 2-bit BHT.
// Each entry holds the BHT index and the counter value read at predict time.
// Resolutions pop the head, compute the next hysteresis state and issue a
// registered BHT write. The new state is also forwarded into younger queued
// entries (and a same-cycle push) that share the index, so they never carry
// a stale counter value.
// Optional build macro: BHT_UPDATE_STATS_EN adds stat_resolved/stat_mispred.
module bht_update_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pred_valid,
    input  logic [AW-1:0]            pred_addr,
    input  logic [1:0]               pred_state,
    output logic                     pred_ready,
    input  logic                     res_valid,
    input  logic                     res_taken,
    output logic                     res_ready,
    input  logic                     flush,
    output logic                     bht_wr,
    output logic [AW-1:0]            bht_addr,
    output logic [1:0]               bht_wdata,
    output logic                     mispredict,
    output logic [$clog2(DEPTH):0]   occupancy
`ifdef BHT_UPDATE_STATS_EN
    ,
    output logic [31:0]              stat_resolved,
    output logic [31:0]              stat_mispred
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Entry storage; kept as registers because forwarding touches every entry.
    logic [AW-1:0]   addr_mem  [DEPTH];
    logic [1:0]      state_mem [DEPTH];

    logic [PW-1:0]   head_reg;
    logic [PW-1:0]   tail_reg;
    logic [CW-1:0]   count_reg;

    logic            bht_wr_reg;
    logic [AW-1:0]   bht_addr_reg;
    logic [1:0]      bht_wdata_reg;
    logic            mispredict_reg;

    logic            push_ok;
    logic            pop_ok;
    logic [AW-1:0]   head_addr;
    logic [1:0]      head_state;
    logic [1:0]      state_next;
    logic            mis_next;
    logic            push_fwd;

    logic [DEPTH-1:0] push_hit;
    logic [DEPTH-1:0] fwd_hit;

    assign pred_ready = (count_reg != CW'(DEPTH));
    assign res_ready  = (count_reg != '0);
    assign push_ok    = pred_valid && pred_ready;
    assign pop_ok     = res_valid && res_ready;

    assign head_addr  = addr_mem[head_reg];
    assign head_state = state_mem[head_reg];
    assign mis_next   = (head_state[1] != res_taken);
    assign push_fwd   = pop_ok && (pred_addr == head_addr);

    assign bht_wr     = bht_wr_reg;
    assign bht_addr   = bht_addr_reg;
    assign bht_wdata  = bht_wdata_reg;
    assign mispredict = mispredict_reg;
    assign occupancy  = count_reg;

    // 2-bit hysteresis: strong states need two wrong outcomes to flip.
    always_comb begin
        state_next = 2'b00;
        case (head_state)
            2'b00:   state_next = res_taken ? 2'b01 : 2'b00;
            2'b01:   state_next = res_taken ? 2'b11 : 2'b00;
            2'b10:   state_next = res_taken ? 2'b11 : 2'b00;
            default: state_next = res_taken ? 2'b11 : 2'b10;
        endcase
    end

    // Per-entry write selects: tail slot for a push, index match for forwarding.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign push_hit[gi] = push_ok && !flush && (tail_reg == PW'(gi));
            assign fwd_hit[gi]  = pop_ok && (addr_mem[gi] == head_addr);
        end
    endgenerate

    // Entry storage update; a push into a slot takes priority over forwarding.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push_hit[i]) begin
                addr_mem[i]  <= pred_addr;
                state_mem[i] <= push_fwd ? state_next : pred_state;
            end else if (fwd_hit[i]) begin
                state_mem[i] <= state_next;
            end
        end
    end

    // Head/tail pointers and occupancy; flush empties the queue outright.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push_ok) tail_reg <= tail_reg + 1'b1;
            if (pop_ok)  head_reg <= head_reg + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Registered BHT writeback and mispredict pulse; addr/data hold when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bht_wr_reg     <= 1'b0;
            bht_addr_reg   <= '0;
            bht_wdata_reg  <= 2'b00;
            mispredict_reg <= 1'b0;
        end else begin
            bht_wr_reg     <= pop_ok;
            mispredict_reg <= pop_ok && mis_next;
            if (pop_ok) begin
                bht_addr_reg  <= head_addr;
                bht_wdata_reg <= state_next;
            end
        end
    end

`ifdef BHT_UPDATE_STATS_EN
    logic [31:0] stat_resolved_reg;
    logic [31:0] stat_mispred_reg;

    assign stat_resolved = stat_resolved_reg;
    assign stat_mispred  = stat_mispred_reg;

    // Free-running event counters; only reset clears them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_resolved_reg <= '0;
            stat_mispred_reg  <= '0;
        end else begin
            if (pop_ok)             stat_resolved_reg <= stat_resolved_reg + 32'd1;
            if (pop_ok && mis_next) stat_mispred_reg  <= stat_mispred_reg + 32'd1;
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_bht_update_queue.sv
// Testbench for bht_update_queue: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_bht_update_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 10;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            pred_valid = 1'b0;
    logic [AW-1:0]   pred_addr = '0;
    logic [1:0]      pred_state = 2'b00;
    logic            pred_ready;
    logic            res_valid = 1'b0;
    logic            res_taken = 1'b0;
    logic            res_ready;
    logic            flush = 1'b0;
    logic            bht_wr;
    logic [AW-1:0]   bht_addr;
    logic [1:0]      bht_wdata;
    logic            mispredict;
    logic [2:0]      occupancy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [1:0]    s;
    } ent_t;

    ent_t          mq[$];
    logic          e_wr, e_mp;
    logic [AW-1:0] e_addr;
    logic [1:0]    e_data;

    bht_update_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pred_valid (pred_valid),
        .pred_addr  (pred_addr),
        .pred_state (pred_state),
        .pred_ready (pred_ready),
        .res_valid  (res_valid),
        .res_taken  (res_taken),
        .res_ready  (res_ready),
        .flush      (flush),
        .bht_wr     (bht_wr),
        .bht_addr   (bht_addr),
        .bht_wdata  (bht_wdata),
        .mispredict (mispredict),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    // Counter update rule written as a saturating walk with a strong-state
    // exception: taken from 01/10 jumps to 11, not-taken from 11 drops to 10.
    function automatic logic [1:0] nxt(input logic [1:0] s, input logic t);
        if (t) return (s == 2'b00) ? 2'b01 : 2'b11;
        else   return (s == 2'b11) ? 2'b10 : 2'b00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus, model update, and output comparison.
    task automatic step(input logic pv, input logic [AW-1:0] pa, input logic [1:0] ps,
                        input logic rv, input logic rt, input logic fl, input logic rn);
        logic pu, po;
        ent_t h, n;
        logic [1:0] ns;
        @(negedge clk);
        pred_valid = pv; pred_addr = pa; pred_state = ps;
        res_valid = rv; res_taken = rt; flush = fl; rst_n = rn;
        ns = 2'b00;
        h.a = '0; h.s = 2'b00;
        if (!rn) begin
            mq.delete();
            e_wr = 0; e_mp = 0; e_addr = '0; e_data = 2'b00;
        end else begin
            pu = pv && (mq.size() < DEPTH);
            po = rv && (mq.size() > 0);
            e_wr = po; e_mp = 0;
            if (po) begin
                h = mq.pop_front();
                ns = nxt(h.s, rt);
                e_mp = (h.s[1] != rt);
                e_addr = h.a; e_data = ns;
                foreach (mq[i]) if (mq[i].a == h.a) mq[i].s = ns;
            end
            if (fl) mq.delete();
            else if (pu) begin
                n.a = pa;
                n.s = (po && pa == h.a) ? ns : ps;
                mq.push_back(n);
            end
        end
        @(posedge clk);
        #1;
        $display("t=%0t pv=%0b pa=%0h ps=%0b rv=%0b rt=%0b fl=%0b rn=%0b -> wr=%0b addr=%0h wd=%0b mp=%0b occ=%0d",
                 $time, pv, pa, ps, rv, rt, fl, rn, bht_wr, bht_addr, bht_wdata, mispredict, occupancy);
        chk("bht_wr", bht_wr, e_wr);
        chk("mispredict", mispredict, e_mp);
        chk("bht_addr", bht_addr, e_addr);
        chk("bht_wdata", bht_wdata, e_data);
        chk("occupancy", occupancy, mq.size());
        chk("pred_ready", pred_ready, mq.size() != DEPTH);
        chk("res_ready", res_ready, mq.size() != 0);
    endtask

    initial begin
        logic [1:0] cur;
        logic [AW-1:0] ra;

        // Reset
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_wr", bht_wr, 0);

        // Single branch
        step(1, 10'h155, 2'b00, 0, 0, 0, 1);
        chk("t1_occ1", occupancy, 1);
        step(0, 0, 0, 1, 1, 0, 1);
        chk("t1_addr", bht_addr, 10'h155);
        chk("t1_wdata", bht_wdata, 2'b01);
        chk("t1_mp", mispredict, 1);
        chk("t1_occ0", occupancy, 0);

        // Hysteresis walk from 11 on addr 0x003, outcomes N,T,N,N
        cur = 2'b11;
        for (int i = 0; i < 4; i++) begin
            step(1, 10'h003, cur, 0, 0, 0, 1);
            step(0, 0, 0, 1, (i == 1), 0, 1);
            cur = bht_wdata;
        end
        chk("walk_final", bht_wdata, 2'b00);

        // Full / empty
        for (int i = 0; i < 5; i++) step(1, AW'(i + 16), 2'(i), 0, 0, 0, 1);
        chk("full_ready", pred_ready, 0);
        chk("full_occ", occupancy, 4);
        step(1, 10'h3ff, 2'b11, 1, 1, 0, 1);
        chk("full_pushpop_occ", occupancy, 3);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, 1);
        chk("empty_rready", res_ready, 0);
        step(0, 0, 0, 1, 1, 0, 1);
        chk("empty_nowr", bht_wr, 0);

        // Forwarding
        step(1, 10'h020, 2'b01, 0, 0, 0, 1);
        step(1, 10'h020, 2'b01, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1, 0, 1);
        chk("fwd_w1", bht_wdata, 2'b11);
        step(0, 0, 0, 1, 0, 0, 1);
        chk("fwd_w2", bht_wdata, 2'b10);
        chk("fwd_mp2", mispredict, 1);

        // Flush with simultaneous pop and push
        step(1, 10'h0a0, 2'b10, 0, 0, 0, 1);
        step(1, 10'h0a1, 2'b00, 0, 0, 0, 1);
        step(1, 10'h0a2, 2'b01, 0, 0, 0, 1);
        step(1, 10'h0a3, 2'b11, 1, 1, 1, 1);
        chk("flush_wr", bht_wr, 1);
        chk("flush_wd", bht_wdata, 2'b11);
        chk("flush_occ", occupancy, 0);
        step(0, 0, 0, 1, 1, 0, 1);
        chk("flush_nowr", bht_wr, 0);

        // Reset mid-operation
        step(1, 10'h011, 2'b10, 0, 0, 0, 1);
        step(1, 10'h012, 2'b01, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1, 0, 0);
        chk("mrst_wr", bht_wr, 0);
        chk("mrst_mp", mispredict, 0);
        chk("mrst_occ", occupancy, 0);

        // Random traffic over a small address pool to exercise forwarding
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0: ra = 10'h003;
                1: ra = 10'h020;
                2: ra = 10'h155;
                default: ra = AW'($urandom);
            endcase
            step($urandom_range(0, 2) != 0, ra, 2'($urandom), $urandom_range(0, 2) != 0,
                 1'($urandom), $urandom_range(0, 40) == 0, $urandom_range(0, 150) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
